adder_seq_ctrl: RTL and testbench

//  Sequencer that reuses one external 4-bit ripple-carry adder (ports a,b,ci -> s,co)
//  to add NIBBLES*4-bit operands, one nibble per clock, LSB nibble first.
//  The adder sits outside this block and is purely combinational.

---
 rtl/adder_seq_ctrl_if.sv | 25 ++
 rtl/adder_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_adder_seq_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/adder_seq_ctrl_if.sv
// Requester-side handshake for adder_seq_ctrl: start/operands in, busy/done/result out.
// ADDER_SEQ_SUB_EN adds the sub request bit.
interface adder_seq_ctrl_if #(parameter int NIBBLES = 4);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
`ifdef ADDER_SEQ_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

`ifdef ADDER_SEQ_SUB_EN
    modport master (output start, x, y, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, x, y, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, x, y, cin, input busy, done, sum, cout);
    modport slave  (input start, x, y, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/adder_seq_ctrl.sv
// Nibble-serial add sequencer driving one external 4-bit combinational adder, LSB first.
// Define ADDER_SEQ_SUB_EN to add the subtract request (y inverted, carry forced to 1).
module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_seq_ctrl_if.slave       req,
    output logic [3:0]            add_a,
    output logic [3:0]            add_b,
    output logic                  add_ci,
    input  logic [3:0]            add_s,
    input  logic                  add_co
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    // state  | meaning
    // S_IDLE | waiting for start, adder inputs parked at 0
    // S_RUN  | one nibble per cycle through the external adder
    // S_DONE | one-cycle done pulse, result stable
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [IW-1:0]            idx;
    logic                     carry;
    logic [NIBBLES-1:0][3:0]  xr;
    logic [NIBBLES-1:0][3:0]  yr;
    logic [NIBBLES-1:0][3:0]  sum_r;
    logic                     cout_r;
    logic                     last;
    logic                     busy;
    logic                     done;

    assign last     = (idx == IW'(NIBBLES - 1));
    assign req.busy = busy;
    assign req.done = done;
    assign req.sum  = sum_r;
    assign req.cout = cout_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        add_a     = 4'h0;
        add_b     = 4'h0;
        add_ci    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req.start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                add_a  = xr[idx];
                add_b  = yr[idx];
                add_ci = carry;
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            xr     <= '0;
            yr     <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req.start) begin
                        xr  <= req.x;
                        idx <= '0;
`ifdef ADDER_SEQ_SUB_EN
                        // Two's-complement subtract: x + ~y + 1; cout=1 means no borrow.
                        yr    <= req.sub ? ~req.y : req.y;
                        carry <= req.sub ? 1'b1 : req.cin;
`else
                        yr    <= req.y;
                        carry <= req.cin;
`endif
                    end
                end
                S_RUN: begin
                    sum_r[idx] <= add_s;
                    carry      <= add_co;
                    if (last) begin
                        cout_r <= add_co;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl (NIBBLES=4) with a behavioural 4-bit adder on the add_* port.
// Subtract vectors run only when ADDER_SEQ_SUB_EN is defined.
module tb_adder_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_ci;
    logic [3:0] add_s;
    logic       add_co;
    int         n_checks = 0;
    int         n_errors = 0;

    adder_seq_ctrl_if #(.NIBBLES(4)) req();

    adder_seq_ctrl #(.NIBBLES(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .add_a  (add_a),
        .add_b  (add_b),
        .add_ci (add_ci),
        .add_s  (add_s),
        .add_co (add_co)
    );

    always #5 clk = ~clk;

    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [15:0] xv, input logic [15:0] yv, input logic ci, input logic sb);
        req.x   = xv;
        req.y   = yv;
        req.cin = ci;
`ifdef ADDER_SEQ_SUB_EN
        req.sub = sb;
`else
        if (sb) $display("note: sub requested without ADDER_SEQ_SUB_EN");
`endif
    endtask

    // Called at a negedge: one operation, done expected in the 5th cycle after the start edge.
    task automatic run_op(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                          input logic ci, input logic sb,
                          input logic [15:0] es, input logic ec);
        int first;
        int nd;
        first = 0;
        nd    = 0;
        set_req(xv, yv, ci, sb);
        req.start = 1'b1;
        @(negedge clk);
        req.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) check({tag, "_busy_run"}, 32'(req.busy), 32'd1);
            if (req.done) begin
                nd++;
                if (first == 0) first = c;
            end
            @(negedge clk);
        end
        check({tag, "_done_cycle"}, 32'(first), 32'd5);
        check({tag, "_done_count"}, 32'(nd), 32'd1);
        check({tag, "_busy_after"}, 32'(req.busy), 32'd0);
        check({tag, "_sum"}, 32'(req.sum), 32'(es));
        check({tag, "_cout"}, 32'(req.cout), 32'(ec));
    endtask

    initial begin
        int first;
        int nd;
        int gap;
        int last_done;
        int cyc;
        int waited;
        logic [15:0] bx;
        logic [15:0] by;
        logic        bc;
        logic [16:0] bexp;

        rst_n     = 1'b0;
        req.start = 1'b0;
        set_req(16'h0, 16'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(req.busy), 32'd0);
        check("rst_done", 32'(req.done), 32'd0);
        check("rst_sum", 32'(req.sum), 32'd0);
        check("rst_cout", 32'(req.cout), 32'd0);
        check("rst_add_a", 32'(add_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
        check("t1_idle_add_a", 32'(add_a), 32'd0);
        check("t1_idle_add_ci", 32'(add_ci), 32'd0);
        run_op("t2a", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_op("t2b", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);

        // Starts during RUN (cycle 2) and DONE (cycle 5) must be dropped.
        first = 0;
        nd    = 0;
        set_req(16'h0001, 16'h0001, 1'b0, 1'b0);
        req.start = 1'b1;
        @(negedge clk);
        req.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (req.done) begin
                nd++;
                if (first == 0) first = c;
            end
            if (c == 6) check("t3_busy_after", 32'(req.busy), 32'd0);
            if (c == 2 || c == 5) begin
                req.x     = 16'hAAAA;
                req.y     = 16'hAAAA;
                req.start = 1'b1;
            end else begin
                req.start = 1'b0;
            end
            @(negedge clk);
        end
        check("t3_done_cycle", 32'(first), 32'd5);
        check("t3_done_count", 32'(nd), 32'd1);
        check("t3_sum", 32'(req.sum), 32'h0002);
        check("t3_cout", 32'(req.cout), 32'd0);

        // Reset sampled at the second RUN edge.
        set_req(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        req.start = 1'b1;
        @(negedge clk);
        req.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t4_busy", 32'(req.busy), 32'd0);
        check("t4_done", 32'(req.done), 32'd0);
        check("t4_sum", 32'(req.sum), 32'd0);
        check("t4_cout", 32'(req.cout), 32'd0);
        rst_n = 1'b1;
        nd = 0;
        repeat (8) begin
            if (req.done) nd++;
            @(negedge clk);
        end
        check("t4_no_done", 32'(nd), 32'd0);
        run_op("t4b", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0);

        // Start held high: one accept every 6 cycles, results against x+y+cin.
        bx = 16'($urandom);
        by = 16'($urandom);
        bc = 1'($urandom);
        set_req(bx, by, bc, 1'b0);
        req.start = 1'b1;
        cyc       = 0;
        last_done = 0;
        for (int i = 0; i < 1000; i++) begin
            waited = 0;
            do begin
                @(negedge clk);
                cyc++;
                waited++;
            end while (!req.done && waited < 12);
            if (!req.done) begin
                check("t5_timeout", 32'd0, 32'd1);
                break;
            end
            bexp = {1'b0, bx} + {1'b0, by} + {16'b0, bc};
            check("t5_result", 32'({req.cout, req.sum}), 32'(bexp));
            if (i > 0) begin
                gap = cyc - last_done;
                check("t5_period", 32'(gap), 32'd6);
            end
            last_done = cyc;
            bx = 16'($urandom);
            by = 16'($urandom);
            bc = 1'($urandom);
            set_req(bx, by, bc, 1'b0);
        end
        req.start = 1'b0;
        repeat (8) @(negedge clk);

`ifdef ADDER_SEQ_SUB_EN
        run_op("t6a", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        run_op("t6b", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
        run_op("t6c", 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
